// File: rtl/ad9653_bitslip_align_pkg.sv
// Shared constants and helpers for the AD9653 bitslip alignment sequencer.
//   BYTE_W  : deserialized bits per LVDS lane
//   SLIP_W  : width of each per-lane slip counter field in slip_count
//   sat_inc : saturating increment used by the slip counters
package ad9653_bitslip_align_pkg;
  localparam int BYTE_W = 8;
  localparam int SLIP_W = 4;

  function automatic logic [SLIP_W-1:0] sat_inc(input logic [SLIP_W-1:0] v,
                                                input logic [SLIP_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/ad9653_bitslip_align_lane_check.sv
// align_lane_check: picks the byte of the lane under test, compares it to
// PATTERN and keeps a saturating count of consecutive matching cycles.
//   clk, reset : clk_div clock, synchronous active-high reset
//   lane       : index of the lane under test
//   dout       : all deserialized lane bytes, lane i at dout[8*i+7:8*i]
//   en         : high while the sequencer is checking; low clears the run
//   match      : selected byte equals PATTERN this cycle
//   reached    : this cycle's match completes CHECK_LEN consecutive matches
module align_lane_check
  import ad9653_bitslip_align_pkg::*;
#(
  parameter int          DWIDTH    = 8,
  parameter logic [7:0]  PATTERN   = 8'h1D,
  parameter int          CHECK_LEN = 16,
  localparam int         LW        = (DWIDTH > 1) ? $clog2(DWIDTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LW-1:0]            lane,
  input  logic [BYTE_W*DWIDTH-1:0] dout,
  input  logic                     en,
  output logic                     match,
  output logic                     reached
);
  localparam int RW = $clog2(CHECK_LEN + 1);

  logic [DWIDTH-1:0][BYTE_W-1:0] lanes;
  logic [RW-1:0]                 run_cnt;

  assign lanes   = dout;
  assign match   = (lanes[lane] == PATTERN);
  assign reached = match && (run_cnt == RW'(CHECK_LEN - 1));

  // Any mismatch restarts the run; leaving the check window clears it so
  // every check window starts from zero.
  always_ff @(posedge clk) begin
    if (reset || !en)
      run_cnt <= '0;
    else if (!match)
      run_cnt <= '0;
    else if (run_cnt != RW'(CHECK_LEN))
      run_cnt <= run_cnt + 1'b1;
  end
endmodule

// File: rtl/ad9653_bitslip_align.sv
// ad9653_bitslip_align: walks the AD9653 ISERDES lanes one at a time while the
// ADC sends a fixed test pattern, slipping each lane until its byte matches
// PATTERN for CHECK_LEN consecutive cycles or MAX_SLIP slips are spent.
//   clk, reset : clk_div clock, synchronous active-high reset
//   start      : one-cycle request, accepted only when idle
//   lane_mask  : lanes to align, latched on accepted start
//   dout       : deserialized lane bytes, lane i at dout[8*i+7:8*i]
//   bitslip    : per-lane bitslip level, one-hot or zero, high only in SLIP
//   busy       : pass in progress
//   done       : one-cycle pulse at the end of a pass
//   lane_ok    : lanes aligned in the last pass
//   slip_count : 4-bit slips issued per lane in the last pass
//   fail       : some masked lane ran out of slips in the last pass
module ad9653_bitslip_align
  import ad9653_bitslip_align_pkg::*;
#(
  parameter int         DWIDTH    = 8,
  parameter logic [7:0] PATTERN   = 8'h1D,
  parameter int         CHECK_LEN = 16,
  parameter int         SETTLE    = 8,
  parameter int         PULSE_LEN = 2,
  parameter int         MAX_SLIP  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DWIDTH-1:0]     lane_mask,
  input  logic [8*DWIDTH-1:0]   dout,
  output logic [DWIDTH-1:0]     bitslip,
  output logic                  busy,
  output logic                  done,
  output logic [DWIDTH-1:0]     lane_ok,
  output logic [4*DWIDTH-1:0]   slip_count,
  output logic                  fail
);
  localparam int LW   = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam int TMAX = (SETTLE > PULSE_LEN) ? SETTLE : PULSE_LEN;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_SETTLE, S_CHECK, S_SLIP, S_NEXT, S_FIN
  } state_t;

  state_t                         state, state_nxt;
  logic [LW-1:0]                  lane;
  logic [DWIDTH-1:0]              mask;
  logic [TW-1:0]                  timer;
  logic [SLIP_W-1:0]              slips;
  logic [DWIDTH-1:0][SLIP_W-1:0]  slip_q;
  logic                           match, reached;

  assign slip_count = slip_q;

  align_lane_check #(
    .DWIDTH    (DWIDTH),
    .PATTERN   (PATTERN),
    .CHECK_LEN (CHECK_LEN)
  ) u_check (
    .clk     (clk),
    .reset   (reset),
    .lane    (lane),
    .dout    (dout),
    .en      (state == S_CHECK),
    .match   (match),
    .reached (reached)
  );

  always_comb begin
    state_nxt = state;
    bitslip   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SEL;
      S_SEL: begin
        busy      = 1'b1;
        state_nxt = mask[lane] ? S_SETTLE : S_NEXT;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (timer == TW'(SETTLE - 1)) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (!match)
          state_nxt = (slips == SLIP_W'(MAX_SLIP)) ? S_NEXT : S_SLIP;
        else if (reached)
          state_nxt = S_NEXT;
      end
      S_SLIP: begin
        busy          = 1'b1;
        bitslip[lane] = 1'b1;
        if (timer == TW'(PULSE_LEN - 1)) state_nxt = S_SETTLE;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = (lane == LW'(DWIDTH - 1)) ? S_FIN : S_SEL;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      lane    <= '0;
      mask    <= '0;
      timer   <= '0;
      slips   <= '0;
      lane_ok <= '0;
      slip_q  <= '0;
      fail    <= 1'b0;
    end else begin
      state <= state_nxt;
      // Timer only runs inside SETTLE/SLIP and restarts on every state change.
      if (state_nxt != state || !(state == S_SETTLE || state == S_SLIP))
        timer <= '0;
      else
        timer <= timer + 1'b1;

      case (state)
        S_IDLE: if (start) begin
          mask    <= lane_mask;
          lane    <= '0;
          lane_ok <= '0;
          slip_q  <= '0;
          fail    <= 1'b0;
        end
        S_SEL: slips <= '0;
        S_CHECK: begin
          if (!match) begin
            if (slips == SLIP_W'(MAX_SLIP)) begin
              fail <= 1'b1;
            end else begin
              // Counted on the way into SLIP.
              slips        <= sat_inc(slips, SLIP_W'(MAX_SLIP));
              slip_q[lane] <= sat_inc(slips, SLIP_W'(MAX_SLIP));
            end
          end else if (reached) begin
            lane_ok[lane] <= 1'b1;
          end
        end
        S_NEXT: if (lane != LW'(DWIDTH - 1)) lane <= lane + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ad9653_bitslip_align.sv
// Bench for ad9653_bitslip_align: rotating-lane ADC model plus a per-pass
// timeline model of what bitslip/busy/done must be on each cycle.
module tb_ad9653_bitslip_align;
  localparam int         DW  = 8;
  localparam logic [7:0] PAT = 8'h1D;
  localparam int         CL  = 16;
  localparam int         ST  = 8;
  localparam int         PL  = 2;
  localparam int         MS  = 8;
  localparam int         NT  = 1024;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [DW-1:0]   lane_mask;
  logic [8*DW-1:0] dout;
  logic [DW-1:0]   bitslip, lane_ok;
  logic            busy, done, fail;
  logic [4*DW-1:0] slip_count;

  always #5 clk = ~clk;

  ad9653_bitslip_align #(
    .DWIDTH(DW), .PATTERN(PAT), .CHECK_LEN(CL), .SETTLE(ST), .PULSE_LEN(PL), .MAX_SLIP(MS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .lane_mask(lane_mask), .dout(dout),
    .bitslip(bitslip), .busy(busy), .done(done), .lane_ok(lane_ok),
    .slip_count(slip_count), .fail(fail)
  );

  // ---------------- ADC / capture environment ----------------
  int            cyc = 0;
  logic [2:0]    pos [DW];
  logic [2:0]    init_pos [DW];
  logic          load = 1'b0;
  logic [DW-1:0] bs_q = '0;
  logic [DW-1:0] rose = '0;
  int            rise_cnt [DW];
  logic [DW-1:0] stuck = '0;
  bit            g_en = 1'b0;
  int            g_lane = 0, g_t = 0, g_abs = -1;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    bs_q <= bitslip;
    for (int i = 0; i < DW; i++) begin
      if (load) begin
        pos[i]      <= init_pos[i];
        rise_cnt[i] <= 0;
        rose[i]     <= 1'b0;
      end else if (bitslip[i] && !bs_q[i]) begin
        pos[i]      <= pos[i] - 3'd1;
        rise_cnt[i] <= rise_cnt[i] + 1;
        rose[i]     <= 1'b1;
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DW; i++) begin
      if (stuck[i])                             dout[8*i +: 8] = 8'h00;
      else if (g_en && i == g_lane && cyc == g_abs) dout[8*i +: 8] = ~PAT;
      else                                      dout[8*i +: 8] = rotl(PAT, int'(pos[i]));
    end
  end

  // ---------------- timeline model ----------------
  logic [DW-1:0]   exp_bs [NT];
  bit              exp_busy [NT];
  bit              exp_done [NT];
  int              m_fin;
  logic [DW-1:0]   m_ok;
  logic [4*DW-1:0] m_slips;
  bit              m_fail;

  function automatic logic [7:0] env_byte(input int ln, input int p, input int t);
    if (stuck[ln]) return 8'h00;
    if (g_en && ln == g_lane && t == g_t) return ~PAT;
    return rotl(PAT, p);
  endfunction

  // Cycle 1 is the first cycle after the start edge. Each lane costs one
  // select cycle and one advance cycle; masked lanes insert settle/compare
  // windows and slip pulses in between until aligned or out of slips.
  task automatic build_model(input logic [DW-1:0] m);
    int t, p, run, slips;
    bit ok, fin_lane;
    for (int k = 0; k < NT; k++) begin
      exp_bs[k] = '0; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
    end
    m_ok = '0; m_slips = '0; m_fail = 1'b0; t = 1;
    for (int ln = 0; ln < DW; ln++) begin
      exp_busy[t] = 1'b1; t++;
      if (m[ln]) begin
        p = int'(init_pos[ln]); slips = 0; fin_lane = 1'b0;
        while (!fin_lane) begin
          for (int k = 0; k < ST; k++) begin exp_busy[t] = 1'b1; t++; end
          run = 0; ok = 1'b1;
          while (ok && run < CL) begin
            exp_busy[t] = 1'b1;
            if (env_byte(ln, p, t) == PAT) run++; else ok = 1'b0;
            t++;
          end
          if (ok) begin
            m_ok[ln] = 1'b1; fin_lane = 1'b1;
          end else if (slips == MS) begin
            m_fail = 1'b1; fin_lane = 1'b1;
          end else begin
            slips++;
            for (int k = 0; k < PL; k++) begin
              exp_busy[t] = 1'b1; exp_bs[t][ln] = 1'b1; t++;
            end
            p = (p + 7) % 8;
          end
        end
        m_slips[4*ln +: 4] = 4'(slips);
      end
      exp_busy[t] = 1'b1; t++;
    end
    exp_done[t] = 1'b1;
    m_fin = t;
  endtask

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;
  int last_done;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic run_pass(input string nm, input logic [DW-1:0] m, input int restart_t);
    int base;
    build_model(m);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    start = 1'b1; lane_mask = m; base = cyc; g_abs = base + g_t;
    @(negedge clk); start = 1'b0; lane_mask = ~m;
    last_done = -1;
    for (int t = 1; t <= m_fin + 3; t++) begin
      if (t == restart_t) start = 1'b1;
      check($sformatf("%s t%0d bs/busy/done", nm, t),
            {bitslip, busy, done}, {exp_bs[t], exp_busy[t], exp_done[t]});
      if (t == 1) check({nm, " cleared on start"}, {lane_ok, slip_count, fail}, '0);
      if (done && last_done < 0) last_done = t;
      @(negedge clk); start = 1'b0;
    end
    check({nm, " lane_ok"}, lane_ok, m_ok);
    check({nm, " slip_count"}, slip_count, m_slips);
    check({nm, " fail"}, fail, m_fail);
  endtask

  task automatic set_pos(input int l0, input int l1, input int l2, input int l3,
                         input int l4, input int l5, input int l6, input int l7);
    init_pos[0] = 3'(l0); init_pos[1] = 3'(l1); init_pos[2] = 3'(l2); init_pos[3] = 3'(l3);
    init_pos[4] = 3'(l4); init_pos[5] = 3'(l5); init_pos[6] = 3'(l6); init_pos[7] = 3'(l7);
  endtask

  initial begin
    bit found;
    int done_seen;
    reset = 1'b1; start = 1'b0; lane_mask = '0;
    set_pos(0, 0, 0, 0, 0, 0, 0, 0);
    load = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
    check("reset outputs", {bitslip, busy, done, lane_ok, slip_count, fail}, '0);
    reset = 1'b0;
    @(negedge clk);

    // 1: every lane already aligned
    run_pass("aligned", 8'hFF, 0);
    check("aligned done_at", 64'(last_done), 209);
    check("aligned lane_ok lit", lane_ok, 8'hFF);
    check("aligned slips lit", slip_count, 32'h0);

    // all-zero mask walks select/advance only
    run_pass("nomask", 8'h00, 0);
    check("nomask done_at", 64'(last_done), 17);
    check("nomask lane_ok/fail", {lane_ok, fail}, '0);

    // 2: lane 3 five rotations off
    set_pos(0, 0, 0, 5, 0, 0, 0, 0);
    run_pass("lane3off5", 8'hFF, 0);
    check("lane3off5 rises", 64'(rise_cnt[3]), 5);
    check("lane3off5 slips lit", slip_count, 32'h0000_5000);
    check("lane3off5 done_at", 64'(last_done), 264);

    // 3: lane 6 never shows the pattern
    set_pos(0, 0, 0, 0, 0, 0, 0, 0);
    stuck = 8'h40;
    run_pass("lane6stuck", 8'hFF, 0);
    stuck = 8'h00;
    check("lane6stuck lane_ok lit", lane_ok, 8'hBF);
    check("lane6stuck fail lit", fail, 1'b1);
    check("lane6stuck slips lit", slip_count, 32'h0800_0000);
    check("lane6stuck done_at", 64'(last_done), 282);

    // 4: only lanes 0 and 2 selected; lanes 1 and 5 also misaligned
    set_pos(1, 2, 3, 0, 0, 4, 0, 0);
    run_pass("mask05", 8'h05, 0);
    check("mask05 lane_ok lit", lane_ok, 8'h05);
    check("mask05 slips lit", slip_count, 32'h0000_0301);
    check("mask05 slipped lanes", rose, 8'h05);
    check("mask05 done_at", 64'(last_done), 109);

    // 5: reset during a lane 2 slip, then restart with a start re-pulse mid-pass
    set_pos(0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0; start = 1'b1; lane_mask = 8'hFF;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (bitslip[2]) found = 1'b1;
      else @(negedge clk);
    end
    check("reach lane2 slip", found, 1'b1);
    check("lanes0-1 ok before reset", lane_ok, 8'h03);
    reset = 1'b1;
    @(negedge clk);
    check("reset mid-slip", {bitslip, busy, done, lane_ok, slip_count, fail}, '0);
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) reset = 1'b0;
      if (done || busy || bitslip != '0) done_seen++;
      @(negedge clk);
    end
    check("quiet after reset", 64'(done_seen), 0);
    run_pass("restart", 8'hFF, 30);
    check("restart done_at", 64'(last_done), 242);
    check("restart slips lit", slip_count, 32'h0000_0300);

    // 6: single corrupt byte on lane 0 at compare cycle 10
    set_pos(0, 0, 0, 0, 0, 0, 0, 0);
    g_en = 1'b1; g_lane = 0; g_t = 1 + ST + 10;
    run_pass("glitch", 8'hFF, 0);
    g_en = 1'b0;
    check("glitch slips lit", slip_count, 32'h0000_0008);
    check("glitch lane_ok lit", {lane_ok, fail}, {8'hFF, 1'b0});
    check("glitch done_at", 64'(last_done), 306);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
